pipelined_op_unit: RTL and testbench

- Parametrised successor to the single-op registered arithmetic test block.
- Two-stage pipeline with valid/ready handshakes on input and output.
- Four selectable operations, per-result overflow flag, and a completed-operation counter.
- Sits between a stream source and a stream sink as a reusable compute datapath for the simple-test suite.

---
 rtl/pipelined_op_unit.sv | 120 ++++++++++++
 tb/tb_pipelined_op_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_op_unit.sv
// rtl/pipelined_op_unit.sv - two-stage valid/ready arithmetic pipeline with overflow flag and op counter
module pipelined_op_unit #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sel,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_ovf,
  output logic [COUNT_W-1:0] op_count
);

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [1:0]         s1_sel;

  logic               s2_valid;
  logic [WIDTH-1:0]   s2_data;
  logic [1:0]         s2_sel;
  logic               s2_ovf;

  logic [COUNT_W-1:0] count_q;

  logic               adv1;
  logic               adv2;

  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   dbl;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_ab;
  logic [2*WIDTH-1:0] prod_mix;
  logic               borrow;
  logic [WIDTH-1:0]   res_data;
  logic               res_ovf;

  // A stage may advance when it is empty or the stage after it is moving.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  always_comb begin
    diff     = s1_a - s1_b;
    dbl      = s1_a + s1_a;
    sum      = {1'b0, s1_a} + {1'b0, s1_b};
    borrow   = s1_a < s1_b;
    prod_ab  = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
    prod_mix = {{WIDTH{1'b0}}, diff} * {{WIDTH{1'b0}}, dbl};
    res_data = '0;
    res_ovf  = 1'b0;
    case (s1_sel)
      2'b00: begin
        // Both factors are already wrapped, so the flag also covers the doubling of a.
        res_data = prod_mix[WIDTH-1:0];
        res_ovf  = borrow || s1_a[WIDTH-1] || (|prod_mix[2*WIDTH-1:WIDTH]);
      end
      2'b01: begin
        res_data = sum[WIDTH-1:0];
        res_ovf  = sum[WIDTH];
      end
      2'b10: begin
        res_data = diff;
        res_ovf  = borrow;
      end
      default: begin
        res_data = prod_ab[WIDTH-1:0];
        res_ovf  = |prod_ab[2*WIDTH-1:WIDTH];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sel   <= '0;
      s2_ovf   <= 1'b0;
      count_q  <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a   <= in_a;
          s1_b   <= in_b;
          s1_sel <= in_sel;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= res_data;
          s2_sel  <= s1_sel;
          s2_ovf  <= res_ovf;
        end
      end
      if (s2_valid && out_ready) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_sel   = s2_sel;
  assign out_ovf   = s2_ovf;
  assign op_count  = count_q;

endmodule

// File: tb/tb_pipelined_op_unit.sv
// tb/tb_pipelined_op_unit.sv - scoreboard bench for pipelined_op_unit
module tb_pipelined_op_unit;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;
  logic          out_ovf;
  logic [CW-1:0] op_count;

  pipelined_op_unit #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .out_ovf(out_ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    longint sel;
    longint ovf;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     fails = 0;
  longint exp_count = 0;
  bit     rand_ready = 1'b0;

  function automatic exp_t model(int a, int b, int sel);
    longint m = longint'(1) << W;
    longint d;
    longint t;
    longint p;
    exp_t e;
    e.sel = sel;
    case (sel)
      0: begin
        d = (a - b + m) % m;
        t = (2 * a) % m;
        p = d * t;
        e.data = p % m;
        e.ovf = ((a < b) || (a >= m / 2) || (p >= m)) ? 1 : 0;
      end
      1: begin
        e.data = (a + b) % m;
        e.ovf = ((a + b) >= m) ? 1 : 0;
      end
      2: begin
        e.data = (a - b + m) % m;
        e.ovf = (a < b) ? 1 : 0;
      end
      default: begin
        p = longint'(a) * longint'(b);
        e.data = p % m;
        e.ovf = (p >= m) ? 1 : 0;
      end
    endcase
    return e;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was accepted.
  task automatic send(int a, int b, int sel, output int waits);
    in_valid = 1'b1;
    in_a     = W'(a);
    in_b     = W'(b);
    in_sel   = 2'(sel);
    waits    = 0;
    #1;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    else q.push_back(model(a, b, sel));
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_sel   = 2'($urandom);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_sel", out_sel, e.sel);
          chk("out_ovf", out_ovf, e.ovf);
        end
        chk("op_count_run", op_count, exp_count % (longint'(1) << CW));
        exp_count++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w1, w2, w3, w;
    longint base;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sel = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_op_count", op_count, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    send(5, 3, 0, w);
    idle();
    drain();
    chk("count_after_first", op_count, 1);

    send(3, 5, 0, w);
    idle();
    drain();

    send(200, 100, 1, w1);
    send(16, 16, 3, w2);
    send(9, 4, 2, w3);
    idle();
    chk("b2b_waits", w1 + w2 + w3, 0);
    drain();

    out_ready = 1'b0;
    send(7, 2, 1, w);
    send(100, 50, 3, w);
    in_valid = 1'b1;
    in_a = 8'd33;
    in_b = 8'd200;
    in_sel = 2'd0;
    #1;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("stall_hold_data", out_data, q[0].data);
      chk("stall_hold_sel", out_sel, q[0].sel);
    end
    @(negedge clk);
    base = exp_count;
    out_ready = 1'b1;
    send(33, 200, 0, w);
    idle();
    drain();
    chk("stall_count", op_count, (base + 3) % (longint'(1) << CW));

    out_ready = 1'b0;
    send(1, 2, 1, w);
    send(3, 4, 3, w);
    rst = 1'b1;
    in_valid = 1'b0;
    q.delete();
    exp_count = 0;
    @(negedge clk);
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_op_count", op_count, 0);
    chk("flush_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("flush_no_stale", out_valid, 0);
    end
    @(negedge clk);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      else send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)), w);
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("final_count", op_count, exp_count % (longint'(1) << CW));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
